// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding for the shift-register sequencer
package shift_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// rtl/shift_tick_gen.sv - bit-rate divider producing one tick every p_div running cycles
module shift_tick_gen #(
    parameter int p_div = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int DW = (p_div > 1) ? $clog2(p_div) : 1;

    logic [DW-1:0] div_cnt;
    logic          at_top;

    assign at_top = (div_cnt == DW'(p_div - 1));
    assign tick   = run && at_top;

    // Divider counts 0..p_div-1 while running; clr restarts the bit period.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= at_top ? '0 : div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - word-in/word-out sequencer driving an external parallel-load shift register
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int   p_nbits      = 8,
    parameter int   p_div        = 4,
    parameter logic p_idle_level = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [p_nbits-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [p_nbits-1:0] out_data,
    input  logic               abort,
    output logic               busy,
    input  logic               ser_in,
    output logic               ser_out,
    output logic               bit_strb,
    output logic               sr_load_en,
    output logic [p_nbits-1:0] sr_load,
    output logic               sr_en,
    output logic               sr_d,
    input  logic [p_nbits-1:0] sr_q
);

    localparam int BW = $clog2(p_nbits + 1);

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] bit_cnt;
    logic          run;
    logic          clr;
    logic          tick;
    logic          last_bit;

    // An abort cancels the pending tick so the shift register is left untouched that cycle.
    assign run      = (state == ST_SHIFT) && !abort;
    assign clr      = !run;
    assign last_bit = (bit_cnt == BW'(p_nbits - 1));

    shift_tick_gen #(
        .p_div (p_div)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter: cleared on word acceptance, advanced once per shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            bit_cnt <= '0;
        end else if (tick) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        sr_load_en = 1'b0;
        sr_en      = 1'b0;
        ser_out    = p_idle_level;
        case (state)
            ST_IDLE: begin
                in_ready   = 1'b1;
                busy       = 1'b0;
                sr_load_en = in_valid && !reset;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_out = sr_q[p_nbits-1];
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    sr_en = 1'b1;
                    if (last_bit) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bit_strb = sr_en;
    assign out_data = sr_q;
    assign sr_load  = in_data;
    assign sr_d     = ser_in;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed bench for shift_seq_ctrl paired with an 8-bit shift register
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Instance A: p_div = 1, ser_in looped back from ser_out.
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_abort, a_busy;
    logic       a_ser_in, a_ser_out, a_bit_strb, a_sr_load_en, a_sr_en, a_sr_d;
    logic [7:0] a_in_data, a_out_data, a_sr_load, a_sr_q;

    // Instance B: p_div = 4, ser_in held low.
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_abort, b_busy;
    logic       b_ser_in, b_ser_out, b_bit_strb, b_sr_load_en, b_sr_en, b_sr_d;
    logic [7:0] b_in_data, b_out_data, b_sr_load, b_sr_q;

    assign a_ser_in = a_ser_out;
    assign b_ser_in = 1'b0;

    shift_seq_ctrl #(.p_nbits(8), .p_div(1), .p_idle_level(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .abort(a_abort), .busy(a_busy), .ser_in(a_ser_in), .ser_out(a_ser_out),
        .bit_strb(a_bit_strb), .sr_load_en(a_sr_load_en), .sr_load(a_sr_load),
        .sr_en(a_sr_en), .sr_d(a_sr_d), .sr_q(a_sr_q)
    );

    shift_seq_ctrl #(.p_nbits(8), .p_div(4), .p_idle_level(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .abort(b_abort), .busy(b_busy), .ser_in(b_ser_in), .ser_out(b_ser_out),
        .bit_strb(b_bit_strb), .sr_load_en(b_sr_load_en), .sr_load(b_sr_load),
        .sr_en(b_sr_en), .sr_d(b_sr_d), .sr_q(b_sr_q)
    );

    // External MSB-first shift registers.
    always_ff @(posedge clk) begin
        if (a_sr_load_en)  a_sr_q <= a_sr_load;
        else if (a_sr_en)  a_sr_q <= {a_sr_q[6:0], a_sr_d};
        if (b_sr_load_en)  b_sr_q <= b_sr_load;
        else if (b_sr_en)  b_sr_q <= {b_sr_q[6:0], b_sr_d};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word to instance A and return the cycle on which out_valid first rises.
    task automatic send_a(input logic [7:0] w, output int lat);
        step();
        a_in_valid = 1'b1;
        a_in_data  = w;
        step();
        a_in_valid = 1'b0;
        #1;
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            step();
            #1;
            lat++;
        end
    endtask

    task automatic drain_a();
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        #1;
    endtask

    int         lat;
    int         ones;
    int         strobes[$];
    logic [7:0] got_q[$];
    logic [7:0] words[2];
    int         idx;
    logic       acc;
    logic       seen_valid;

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_abort = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_abort = 0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ser_out", a_ser_out, 1);
        check("rst_sr_en", a_sr_en, 0);
        check("rst_load_en", a_sr_load_en, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        // Test 1: loopback 0xA5 at p_div=1
        step();
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        #1;
        check("t1_load_en", a_sr_load_en, 1);
        step();
        a_in_valid = 1'b0;
        #1;
        check("t1_busy", a_busy, 1);
        check("t1_in_ready", a_in_ready, 0);
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            step();
            #1;
            lat++;
        end
        check("t1_latency", lat, 9);
        check("t1_data", a_out_data, 8'hA5);

        // Test 3: stall in DONE for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            check("t3_out_valid", a_out_valid, 1);
            check("t3_out_data", a_out_data, 8'hA5);
            check("t3_in_ready", a_in_ready, 0);
            check("t3_sr_en", a_sr_en, 0);
        end
        drain_a();
        check("t3_idle_in_ready", a_in_ready, 1);
        check("t3_idle_out_valid", a_out_valid, 0);
        check("t3_idle_busy", a_busy, 0);

        // Test 2: p_div=4, 0xFF with ser_in low
        step();
        b_in_valid = 1'b1;
        b_in_data  = 8'hFF;
        step();
        b_in_valid = 1'b0;
        #1;
        lat  = 1;
        ones = 0;
        while (!b_out_valid && lat < 100) begin
            if (b_ser_out) ones++;
            if (b_bit_strb) strobes.push_back(lat);
            step();
            #1;
            lat++;
        end
        check("t2_latency", lat, 33);
        check("t2_ser_out_ones", ones, 32);
        check("t2_data", b_out_data, 8'h00);
        check("t2_strobe_count", strobes.size(), 8);
        foreach (strobes[k]) check("t2_strobe_cycle", strobes[k], 4 * (k + 1));
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        #1;
        check("t2_idle", b_in_ready, 1);

        // Test 4: abort at third tick, then 0x3C
        step();
        a_in_valid = 1'b1;
        a_in_data  = 8'h5A;
        step();
        a_in_valid = 1'b0;
        step();
        step();
        a_abort = 1'b1;
        #1;
        check("t4_abort_no_shift", a_sr_en, 0);
        check("t4_abort_no_strb", a_bit_strb, 0);
        step();
        a_abort = 1'b0;
        #1;
        check("t4_abort_busy", a_busy, 0);
        check("t4_abort_in_ready", a_in_ready, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            if (a_out_valid) seen_valid = 1'b1;
        end
        check("t4_no_out_valid", seen_valid, 0);
        send_a(8'h3C, lat);
        check("t4_next_latency", lat, 9);
        check("t4_next_data", a_out_data, 8'h3C);
        drain_a();

        // Test 5: reset mid-SHIFT and in DONE
        step();
        a_in_valid = 1'b1;
        a_in_data  = 8'h77;
        step();
        a_in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_shift_busy", a_busy, 0);
        check("t5_shift_in_ready", a_in_ready, 1);
        check("t5_shift_sr_en", a_sr_en, 0);
        check("t5_shift_strb", a_bit_strb, 0);
        check("t5_shift_ser_out", a_ser_out, 1);
        check("t5_shift_out_valid", a_out_valid, 0);
        send_a(8'h77, lat);
        check("t5_done_reached", a_out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_done_out_valid", a_out_valid, 0);
        check("t5_done_busy", a_busy, 0);
        check("t5_done_load_en", a_sr_load_en, 0);

        // Test 6: back-to-back words with out_ready held high
        words[0] = 8'h01;
        words[1] = 8'h80;
        idx = 0;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b1;
        a_in_data  = words[0];
        #1;
        for (int c = 0; c < 100 && got_q.size() < 2; c++) begin
            check("t6_no_overlap", a_sr_load_en & a_sr_en, 0);
            if (a_out_valid) got_q.push_back(a_out_data);
            acc = a_in_valid & a_in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 2) a_in_data = words[idx];
                else         a_in_valid = 1'b0;
            end
            #1;
        end
        a_out_ready = 1'b0;
        check("t6_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t6_word0", got_q[0], 8'h01);
            check("t6_word1", got_q[1], 8'h80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
